// File: rtl/programmable_frequency_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : programmable_frequency_divider_if
// Description : Ratio/mode request channel for programmable_frequency_divider.
//               The requester (master) presents div_value and pulse_mode with
//               div_valid; the divider (slave) accepts when div_ready is high.
// Ports       : div_value  [WIDTH] requested ratio (0 is taken as 1)
//               div_valid  request valid
//               div_ready  divider can accept a request
//               pulse_mode 0 = toggle output, 1 = one-cycle pulse per period
// Revision    : 1.0 - initial release
// ============================================================================
interface programmable_frequency_divider_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] div_value;
  logic             div_valid;
  logic             div_ready;
  logic             pulse_mode;

  modport master (
    output div_value,
    output div_valid,
    output pulse_mode,
    input  div_ready
  );

  modport slave (
    input  div_value,
    input  div_valid,
    input  pulse_mode,
    output div_ready
  );
endinterface
`default_nettype wire

// File: rtl/programmable_frequency_divider.sv
`default_nettype none
// ============================================================================
// Module      : programmable_frequency_divider
// Description : Divides input_clk_digital by a runtime-programmable ratio N,
//               entirely in the clk domain. New ratio/mode requests land in a
//               shadow register and take effect only at a period wrap.
// Ports       : clk                system clock
//               reset              asynchronous, active-low reset
//               input_clk_digital  clock to be divided (edge-detected on clk)
//               cfg                request channel (slave modport)
//               output_clk_digital divided output (registered)
//               period_strobe      one-clk pulse on each period wrap
//               edge_count         current counter value, 0..N-1
// Options     : FREQ_DIV_INPUT_SYNC_EN - when defined, the input passes
//               through a two-flop synchronizer (3-edge latency instead of 1).
// Revision    : 1.0 - initial release
// ============================================================================
module programmable_frequency_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              input_clk_digital,
  programmable_frequency_divider_if.slave   cfg,
  output logic                              output_clk_digital,
  output logic                              period_strobe,
  output logic [WIDTH-1:0]                  edge_count
);

  localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic s;

`ifdef FREQ_DIV_INPUT_SYNC_EN
  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= input_clk_digital;
      sync_2 <= sync_1;
    end
  end

  assign s = sync_2;
`else
  assign s = input_clk_digital;
`endif

  logic             prev;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] n_act;
  logic             mode_act;
  logic [WIDTH-1:0] n_shadow;
  logic             mode_shadow;
  logic             pending;

  logic             in_edge;
  logic             wrap;
  logic             apply;
  logic             transfer;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] n_eff;
  logic             mode_eff;
  logic [WIDTH:0]   half_n;
  logic [WIDTH-1:0] req_n;

  assign in_edge    = s & ~prev;
  assign wrap       = in_edge && (count == (n_act - ONE));
  assign apply      = wrap && pending;
  assign next_count = wrap ? '0 : (count + ONE);

  // Ratio and mode in force for the cycle being produced: the shadow values
  // take over exactly on the wrap that consumes them, so the new period's
  // first output level already uses the new N.
  assign n_eff    = apply ? n_shadow : n_act;
  assign mode_eff = apply ? mode_shadow : mode_act;

  // ceil(N/2), one bit wider so N = 2^WIDTH-1 cannot overflow.
  assign half_n = ({1'b0, n_eff} + {{WIDTH{1'b0}}, 1'b1}) >> 1;

  // A request arriving on a wrap cycle only sees an empty shadow if nothing
  // was pending, so it can never be applied by that same wrap.
  assign transfer      = cfg.div_valid && !pending;
  assign cfg.div_ready = ~pending;
  assign req_n         = (cfg.div_value == '0) ? ONE : cfg.div_value;

  assign edge_count = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev               <= 1'b0;
      count              <= DEF_N - ONE;
      n_act              <= DEF_N;
      mode_act           <= 1'b0;
      n_shadow           <= DEF_N;
      mode_shadow        <= 1'b0;
      pending            <= 1'b0;
      period_strobe      <= 1'b0;
      output_clk_digital <= 1'b0;
    end else begin
      prev          <= s;
      period_strobe <= wrap;

      if (in_edge) begin
        count    <= next_count;
        n_act    <= n_eff;
        mode_act <= mode_eff;
      end

      if (transfer) begin
        n_shadow    <= req_n;
        mode_shadow <= cfg.pulse_mode;
        pending     <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end

      if (mode_eff) begin
        output_clk_digital <= wrap;
      end else if (n_eff == ONE) begin
        // Divide-by-one: bypass, the output follows the conditioned input.
        output_clk_digital <= s;
      end else if (in_edge) begin
        output_clk_digital <= ({1'b0, next_count} < half_n);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_programmable_frequency_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_programmable_frequency_divider
// Description : Self-checking bench for programmable_frequency_divider. A
//               period/position reference model is checked every clk cycle;
//               a table of ratio/mode records checks period length and duty,
//               and hand sequences cover latency, wrap-cycle requests and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_programmable_frequency_divider;

  localparam int W   = 16;
  localparam int DEF = 2;
`ifdef FREQ_DIV_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_clk = 1'b0;
  logic          out_clk;
  logic          strobe;
  logic [W-1:0]  ecount;

  always #5 clk = ~clk;

  programmable_frequency_divider_if #(.WIDTH(W)) cfg_if ();

  programmable_frequency_divider #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk                (clk),
    .reset              (reset),
    .input_clk_digital  (in_clk),
    .cfg                (cfg_if),
    .output_clk_digital (out_clk),
    .period_strobe      (strobe),
    .edge_count         (ecount)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int n; bit mode; } req_t;
  req_t req_q[$];
  bit   dl[$];          // conditioned-input delay line
  int   m_pos, m_n;
  bit   m_mode, m_prev, m_out, m_strobe;

  function automatic void model_reset();
    m_pos = DEF - 1; m_n = DEF; m_mode = 0; m_prev = 0; m_out = 0; m_strobe = 0;
    req_q.delete();
    dl.delete();
    for (int i = 0; i < LAT - 1; i++) dl.push_back(1'b0);
  endfunction

  function automatic void model_step(bit rst_n, bit in_v, bit val, int dv, bit pm);
    bit s, rise, accept;
    req_t r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    dl.push_back(in_v);
    s = dl.pop_front();
    rise = s && !m_prev;
    m_prev = s;
    accept = val && (req_q.size() == 0);
    m_strobe = 0;
    if (rise) begin
      if (m_pos == m_n - 1) begin
        m_pos = 0;
        m_strobe = 1;
        if (req_q.size() > 0) begin
          r = req_q.pop_front();
          m_n = r.n;
          m_mode = r.mode;
        end
      end else begin
        m_pos++;
      end
    end
    if (accept) begin
      r.n = (dv == 0) ? 1 : dv;
      r.mode = pm;
      req_q.push_back(r);
    end
    if (m_mode) m_out = m_strobe;
    else if (m_n == 1) m_out = s;
    else if (rise) m_out = (m_pos < (m_n + 1) / 2);
  endfunction

  function automatic bit next_is_wrap();
    bit s_next;
    s_next = (LAT == 1) ? in_clk : dl[0];
    return s_next && !m_prev && (m_pos == m_n - 1);
  endfunction

  // ---------------- stimulus helpers ----------------
  bit run_in = 0;
  int half = 4;
  int ph = 0;

  task automatic tick();
    bit rv, iv, vv, pm;
    int dv;
    rv = reset; iv = in_clk; vv = cfg_if.div_valid; pm = cfg_if.pulse_mode;
    dv = int'(cfg_if.div_value);
    @(posedge clk);
    model_step(rv, iv, vv, dv, pm);
    #1;
    chk("out", out_clk, m_out);
    chk("strobe", strobe, m_strobe);
    chk("ready", cfg_if.div_ready, req_q.size() == 0);
    chk("count", ecount, m_pos);
    if (run_in) begin
      ph++;
      if (ph >= half) begin
        ph = 0;
        in_clk = ~in_clk;
      end
    end
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (!cfg_if.div_ready && n < limit) begin
      tick();
      n++;
    end
    chk("wait_ready", cfg_if.div_ready, 1);
  endtask

  task automatic wait_strobe(input int limit);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!strobe && n < limit);
    chk("wait_strobe", strobe, 1);
  endtask

  // Assumes the strobe cycle is the current sample; counts to the next one.
  task automatic measure_here(output int iv, output int hv);
    iv = 0; hv = 0;
    do begin
      hv += int'(out_clk);
      iv++;
      tick();
    end while (!strobe && iv < 2000);
    chk("measure_end", strobe, 1);
  endtask

  task automatic request(input int dv, input bit pm);
    wait_ready(5000);
    cfg_if.div_valid  = 1'b1;
    cfg_if.div_value  = W'(dv);
    cfg_if.pulse_mode = pm;
    tick();
    cfg_if.div_valid  = 1'b0;
    chk("ready_drop", cfg_if.div_ready, 0);
  endtask

  typedef struct { int dv; bit pm; int half; int exp_int; int exp_high; } vec_t;
  vec_t tbl[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, iv, hv;
    tbl[0] = '{dv: 5, pm: 0, half: 4, exp_int: 40, exp_high: 24};
    tbl[1] = '{dv: 4, pm: 1, half: 4, exp_int: 32, exp_high: 1};
    tbl[2] = '{dv: 3, pm: 0, half: 3, exp_int: 18, exp_high: 12};
    tbl[3] = '{dv: 0, pm: 0, half: 4, exp_int: 8,  exp_high: 4};
    tbl[4] = '{dv: 1, pm: 0, half: 3, exp_int: 6,  exp_high: 3};
    tbl[5] = '{dv: 7, pm: 1, half: 2, exp_int: 28, exp_high: 1};
    tbl[6] = '{dv: 2, pm: 0, half: 4, exp_int: 16, exp_high: 8};

    cfg_if.div_valid = 1'b0; cfg_if.div_value = '0; cfg_if.pulse_mode = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b1;

    // Reset state
    chk("rst_out", out_clk, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_ready", cfg_if.div_ready, 1);
    chk("rst_count", ecount, DEF - 1);
    repeat (2) tick();

    // First input rise: output rises after LAT edges together with a strobe
    in_clk = 1'b1; run_in = 1; ph = 0; half = 4;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_clk && n < 10);
    chk("first_rise_lat", n, LAT);
    chk("first_strobe", strobe, 1);
    measure_here(iv, hv);
    chk("def_interval", iv, 16);
    chk("def_high", hv, 8);

    // Table-driven ratio/mode changes
    for (int i = 0; i < 7; i++) begin
      half = tbl[i].half;
      request(tbl[i].dv, tbl[i].pm);
      wait_ready(5000);
      chk("apply_at_wrap", strobe, 1);
      wait_strobe(2000);
      measure_here(iv, hv);
      chk($sformatf("tbl%0d_interval", i), iv, tbl[i].exp_int);
      chk($sformatf("tbl%0d_high", i), hv, tbl[i].exp_high);
    end

    // Request landing exactly on a wrap edge; second request while pending
    n = 0;
    while (!next_is_wrap() && n < 200) begin
      tick();
      n++;
    end
    chk("found_wrap", next_is_wrap(), 1);
    cfg_if.div_valid = 1'b1; cfg_if.div_value = W'(3); cfg_if.pulse_mode = 1'b0;
    tick();
    chk("wrap_req_strobe", strobe, 1);
    chk("wrap_req_ready", cfg_if.div_ready, 0);
    cfg_if.div_value = W'(6);
    tick();
    cfg_if.div_valid = 1'b0;
    n = 1;
    while (!strobe && n < 200) begin
      tick();
      n++;
    end
    chk("old_n_kept", n, 16);
    chk("ready_after_apply", cfg_if.div_ready, 1);
    measure_here(iv, hv);
    chk("new_n_interval", iv, 24);
    chk("new_n_high", hv, 16);
    measure_here(iv, hv);
    chk("ignored_req", iv, 24);

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      half = int'($urandom_range(2, 5));
      repeat ($urandom_range(0, 30)) tick();
      cfg_if.div_valid  = 1'b1;
      cfg_if.div_value  = W'($urandom_range(0, 6));
      cfg_if.pulse_mode = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) tick();
      cfg_if.div_valid  = 1'b0;
    end

    // Asynchronous reset with a request pending
    half = 4;
    wait_ready(5000);
    wait_strobe(2000);
    request(5, 1);
    repeat (2) tick();
    chk("pend_before_rst", cfg_if.div_ready, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_out", out_clk, 0);
    chk("arst_strobe", strobe, 0);
    chk("arst_ready", cfg_if.div_ready, 1);
    chk("arst_count", ecount, DEF - 1);
    repeat (2) tick();
    reset = 1'b1;
    wait_strobe(2000);
    measure_here(iv, hv);
    chk("post_rst_interval", iv, 16);
    chk("post_rst_high", hv, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
